// File: rtl/pipe_stage_buf_pkg.sv
// Shared pipeline definitions: buffer occupancy states, default payload widths
// and NOP-style bubble constants used as flush values.
package pipe_stage_buf_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_e;

  localparam int PC_W       = 32;
  localparam int INSTR_W    = 32;
  localparam int DATA_W_DEF = PC_W + INSTR_W;

  // RISC-V canonical NOP (addi x0, x0, 0) in the low word, zero pc above it
  localparam logic [INSTR_W-1:0]      NOP_INSTR = 32'h0000_0013;
  localparam logic [DATA_W_DEF-1:0]   FLUSH_NOP = {{PC_W{1'b0}}, NOP_INSTR};

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Valid/ready/data handshake bundle; master drives valid and data, slave drives ready.
interface pipe_stage_buf_if import pipe_stage_buf_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF
);
  logic              valid;
  logic [DATA_W-1:0] data;
  logic              ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_buf_sat_counter.sv
// Saturating up-counter with enable, shared by the core performance counters.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (enable && (count != CNT_MAX)) begin
      count <= count + CNT_ONE;
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage register with optional 2-entry skid buffer, flush,
// freeze / SRAM-stall hold and a saturating stall-cycle counter.
module pipe_stage_buf import pipe_stage_buf_pkg::*; #(
  parameter int                DATA_W    = DATA_W_DEF,
  parameter int                SKID      = 1,
  parameter logic [DATA_W-1:0] FLUSH_VAL = '0,
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  pipe_stage_buf_if.slave   up,
  pipe_stage_buf_if.master  dn,
  input  logic              flush,
  input  logic              freeze,
  input  logic              mem_ready,
  output logic [CNT_W-1:0]  stall_cnt
);

  buf_state_e        state;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              run_q;
  logic              hold;
  logic              main_full;
  logic              skid_full;
  logic              in_fire;
  logic              out_fire;

  assign hold      = freeze | ~mem_ready;
  assign main_full = (state != ST_EMPTY);
  assign skid_full = (state == ST_TWO);

  // run_q keeps in_ready low throughout reset and lifts it on the first edge after release
  generate
    if (SKID != 0) begin : g_skid
      assign up.ready = run_q & ~skid_full & ~hold;
    end else begin : g_noskid
      assign up.ready = run_q & (~main_full | dn.ready) & ~hold;
    end
  endgenerate

  assign in_fire  = up.valid & up.ready;
  assign out_fire = dn.valid & dn.ready;
  assign dn.valid = main_full & ~hold;
  assign dn.data  = main_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_EMPTY;
      main_q <= FLUSH_VAL;
      skid_q <= FLUSH_VAL;
      run_q  <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (flush) begin
        state  <= ST_EMPTY;
        main_q <= FLUSH_VAL;
      end else if (!hold) begin
        case (state)
          ST_EMPTY: begin
            if (in_fire) begin
              main_q <= up.data;
              state  <= ST_ONE;
            end
          end
          ST_ONE: begin
            if (in_fire && out_fire) begin
              main_q <= up.data;
            end else if (out_fire) begin
              state <= ST_EMPTY;
            end else if (in_fire) begin
              skid_q <= up.data;
              state  <= ST_TWO;
            end
          end
          ST_TWO: begin
            if (out_fire) begin
              main_q <= skid_q;
              state  <= ST_ONE;
            end
          end
          default: state <= ST_EMPTY;
        endcase
      end
    end
  end

  // Beats killed by a flush are not counted as stalled
  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk    (clk),
    .rst    (rst),
    .enable (main_full & ~out_fire & ~flush),
    .count  (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Drives three stage variants (skid, no-skid with NOP flush value, 4-bit counter)
// with shared stimulus and compares each against a queue-based occupancy model.
module tb_pipe_stage_buf;
  import pipe_stage_buf_pkg::*;

  typedef logic [63:0] word_t;

  localparam word_t FV_A = 64'h0;
  localparam word_t FV_B = FLUSH_NOP;
  localparam word_t FV_C = 64'hDEAD_0000_0000_BEEF;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  in_valid = 1'b0;
  word_t in_data = '0;
  logic  out_ready = 1'b0;
  logic  flush = 1'b0;
  logic  freeze = 1'b0;
  logic  mem_ready = 1'b1;

  logic [15:0] a_cnt, b_cnt;
  logic [3:0]  c_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipe_stage_buf_if #(.DATA_W(64)) a_up ();
  pipe_stage_buf_if #(.DATA_W(64)) a_dn ();
  pipe_stage_buf_if #(.DATA_W(64)) b_up ();
  pipe_stage_buf_if #(.DATA_W(64)) b_dn ();
  pipe_stage_buf_if #(.DATA_W(64)) c_up ();
  pipe_stage_buf_if #(.DATA_W(64)) c_dn ();

  assign a_up.valid = in_valid;
  assign a_up.data  = in_data;
  assign a_dn.ready = out_ready;
  assign b_up.valid = in_valid;
  assign b_up.data  = in_data;
  assign b_dn.ready = out_ready;
  assign c_up.valid = in_valid;
  assign c_up.data  = in_data;
  assign c_dn.ready = out_ready;

  pipe_stage_buf #(.DATA_W(64), .SKID(1), .FLUSH_VAL(FV_A), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .up(a_up.slave), .dn(a_dn.master),
    .flush(flush), .freeze(freeze), .mem_ready(mem_ready), .stall_cnt(a_cnt));

  pipe_stage_buf #(.DATA_W(64), .SKID(0), .FLUSH_VAL(FV_B), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .up(b_up.slave), .dn(b_dn.master),
    .flush(flush), .freeze(freeze), .mem_ready(mem_ready), .stall_cnt(b_cnt));

  pipe_stage_buf #(.DATA_W(64), .SKID(1), .FLUSH_VAL(FV_C), .CNT_W(4)) dut_c (
    .clk(clk), .rst(rst), .up(c_up.slave), .dn(c_dn.master),
    .flush(flush), .freeze(freeze), .mem_ready(mem_ready), .stall_cnt(c_cnt));

  logic  obs_valid [3];
  logic  obs_ready [3];
  word_t obs_data  [3];
  word_t obs_cnt   [3];

  assign obs_valid[0] = a_dn.valid;
  assign obs_valid[1] = b_dn.valid;
  assign obs_valid[2] = c_dn.valid;
  assign obs_ready[0] = a_up.ready;
  assign obs_ready[1] = b_up.ready;
  assign obs_ready[2] = c_up.ready;
  assign obs_data[0]  = a_dn.data;
  assign obs_data[1]  = b_dn.data;
  assign obs_data[2]  = c_dn.data;
  assign obs_cnt[0]   = {48'h0, a_cnt};
  assign obs_cnt[1]   = {48'h0, b_cnt};
  assign obs_cnt[2]   = {60'h0, c_cnt};

  // Reference model: each stage is a FIFO of held beats plus the last head value
  word_t mq [3][$];
  word_t head_val [3];
  int    stall [3];
  bit    run [3];

  function automatic bit is_skid(input int i);
    return i != 1;
  endfunction

  function automatic int cnt_max(input int i);
    return (i == 2) ? 15 : 65535;
  endfunction

  function automatic word_t flush_val(input int i);
    case (i)
      0:       return FV_A;
      1:       return FV_B;
      default: return FV_C;
    endcase
  endfunction

  function automatic bit hold_now();
    return freeze || !mem_ready;
  endfunction

  function automatic bit pred_valid(input int i);
    return (mq[i].size() > 0) && !hold_now();
  endfunction

  function automatic bit pred_ready(input int i);
    if (!run[i] || hold_now()) return 1'b0;
    if (is_skid(i)) return mq[i].size() < 2;
    return (mq[i].size() == 0) || out_ready;
  endfunction

  task automatic resetModel();
    for (int i = 0; i < 3; i++) begin
      mq[i].delete();
      head_val[i] = flush_val(i);
      stall[i] = 0;
      run[i] = 1'b0;
    end
  endtask

  task automatic modelStep();
    for (int i = 0; i < 3; i++) begin
      bit inf;
      bit outf;
      inf  = in_valid && pred_ready(i);
      outf = pred_valid(i) && out_ready;
      if (rst) begin
        if (flush) begin
          mq[i].delete();
          head_val[i] = flush_val(i);
        end else begin
          if (mq[i].size() > 0 && !outf && stall[i] < cnt_max(i)) stall[i]++;
          if (outf) void'(mq[i].pop_front());
          if (inf) mq[i].push_back(in_data);
          if (mq[i].size() > 0) head_val[i] = mq[i][0];
        end
        run[i] = 1'b1;
      end
    end
  endtask

  task automatic checkOutput(input string tag, input int idx, input word_t obs, input word_t exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s dut%0d observed=%h expected=%h", tag, idx, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    for (int i = 0; i < 3; i++) begin
      checkOutput({tag, ".valid"}, i, word_t'(obs_valid[i]), word_t'(pred_valid(i)));
      checkOutput({tag, ".ready"}, i, word_t'(obs_ready[i]), word_t'(pred_ready(i)));
      checkOutput({tag, ".data"},  i, obs_data[i], head_val[i]);
      checkOutput({tag, ".stall"}, i, obs_cnt[i], word_t'(stall[i]));
    end
  endtask

  task automatic applyStimulus(input logic r, input logic v, input word_t d, input logic ordy,
                               input logic fl, input logic fr, input logic mr);
    @(negedge clk);
    rst = r; in_valid = v; in_data = d; out_ready = ordy;
    flush = fl; freeze = fr; mem_ready = mr;
    #1;
  endtask

  task automatic step(input string tag, input logic r, input logic v, input word_t d,
                      input logic ordy, input logic fl, input logic fr, input logic mr);
    applyStimulus(r, v, d, ordy, fl, fr, mr);
    checkAll(tag);
    modelStep();
  endtask

  initial begin
    resetModel();
    #1 rst = 1'b0;

    step("reset", 0, 0, '0, 0, 0, 0, 1);
    step("reset", 0, 1, 64'h5, 1, 0, 0, 1);
    step("release", 1, 0, '0, 0, 0, 0, 1);

    step("stream", 1, 1, 64'h1, 1, 0, 0, 1);
    step("stream", 1, 1, 64'h2, 1, 0, 0, 1);
    checkOutput("stream_head1", 0, obs_data[0], 64'h1);
    step("stream", 1, 1, 64'h3, 1, 0, 0, 1);
    checkOutput("stream_head2", 0, obs_data[0], 64'h2);
    step("stream", 1, 0, '0, 1, 0, 0, 1);
    checkOutput("stream_head3", 0, obs_data[0], 64'h3);
    checkOutput("stream_stall", 0, obs_cnt[0], 64'h0);
    step("stream", 1, 0, '0, 1, 0, 0, 1);

    step("bp", 1, 1, 64'hA, 0, 0, 0, 1);
    step("bp", 1, 1, 64'hB, 0, 0, 0, 1);
    step("bp", 1, 0, '0, 0, 0, 0, 1);
    checkOutput("bp_ready_low", 0, word_t'(obs_ready[0]), 64'h0);
    step("bp", 1, 0, '0, 0, 0, 0, 1);
    step("bp_drain", 1, 0, '0, 1, 0, 0, 1);
    checkOutput("bp_first", 0, obs_data[0], 64'hA);
    step("bp_drain", 1, 0, '0, 1, 0, 0, 1);
    checkOutput("bp_second", 0, obs_data[0], 64'hB);
    step("bp_drain", 1, 0, '0, 1, 0, 0, 1);

    step("hold", 1, 1, 64'h55, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) step("freeze", 1, 1, 64'h66, 1, 0, 1, 1);
    for (int k = 0; k < 2; k++) step("memstall", 1, 1, 64'h66, 1, 0, 0, 0);
    step("hold_rel", 1, 0, '0, 1, 0, 0, 1);
    checkOutput("hold_emit", 0, obs_data[0], 64'h55);
    step("hold_rel", 1, 0, '0, 1, 0, 0, 1);

    step("fill", 1, 1, 64'h1111, 0, 0, 0, 1);
    step("fill", 1, 1, 64'h2222, 0, 0, 0, 1);
    step("flush", 1, 1, 64'hC, 0, 1, 1, 1);
    step("post_flush", 1, 0, '0, 1, 0, 0, 1);
    checkOutput("flush_nop", 1, obs_data[1], FLUSH_NOP);
    step("post_flush", 1, 0, '0, 1, 0, 0, 1);

    step("sat", 1, 1, 64'h77, 0, 0, 0, 1);
    for (int k = 0; k < 20; k++) step("sat", 1, 0, '0, 0, 0, 0, 1);
    checkOutput("sat_max", 2, obs_cnt[2], 64'd15);
    for (int k = 0; k < 3; k++) step("sat_drain", 1, 0, '0, 1, 0, 0, 1);

    for (int k = 0; k < 20; k++)
      step("toggle", 1, 1, word_t'(64'h100 + k), logic'(k % 2), 0, 0, 1);
    for (int k = 0; k < 3; k++) step("toggle_drain", 1, 0, '0, 1, 0, 0, 1);

    for (int k = 0; k < 300; k++)
      step("random", 1, logic'($urandom_range(0, 1)), {$urandom, $urandom},
           $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 15) != 0);
    for (int k = 0; k < 3; k++) step("random_drain", 1, 0, '0, 1, 0, 0, 1);

    step("midrst", 1, 1, 64'h99, 0, 0, 0, 1);
    step("midrst", 1, 0, '0, 0, 0, 0, 1);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    resetModel();
    checkAll("async_rst");
    step("midrst_hold", 0, 1, 64'h7, 1, 0, 0, 1);
    step("midrst_rel", 1, 0, '0, 1, 0, 0, 1);
    step("after_rst", 1, 1, 64'h42, 1, 0, 0, 1);
    step("after_rst", 1, 0, '0, 1, 0, 0, 1);
    step("after_rst", 1, 0, '0, 1, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised elastic pipeline-stage register. Successor to the fixed 32-bit pc/instruction stage register.
- Adds a valid/ready handshake on both sides and an optional 2-entry skid buffer, so upstream ready is a registered signal.
- Keeps the existing flush, freeze and memory-ready (SRAM stall) controls.
- Adds a saturating stall-cycle counter for performance monitoring.
- Used between any two core pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
- DATA_W, 64: payload width (pc + instruction concatenated, for example).
- SKID, 1: 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- FLUSH_VAL, 0: value driven on out_data after reset or flush (DATA_W bits).
- CNT_W, 16: width of the stall counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream beat valid
- in_data  in  DATA_W  upstream payload
- in_ready  out  1  stage can accept a beat this cycle
- flush  in  1  synchronous clear of all held beats
- freeze  in  1  hazard stall; hold all contents
- mem_ready  in  1  SRAM ready; 0 = stall, same effect as freeze
- out_valid  out  1  head beat valid to downstream
- out_data  out  DATA_W  head payload
- out_ready  in  1  downstream accepts
- stall_cnt  out  CNT_W  saturating count of stalled cycles

Behaviour:
- hold = freeze | ~mem_ready.
- in_fire = in_valid & in_ready.
- out_fire = out_valid & out_ready.
- Reset (rst=0, async): both entries empty, out_data=FLUSH_VAL, out_valid=0, stall_cnt=0. in_ready=0 while in reset, 1 on the first cycle after release.
- Storage: main register (head) and skid register (SKID=1 only), each with a full flag.
- States: EMPTY (neither full), ONE (main full), TWO (main and skid full; SKID=1 only).
- out_valid = main_full & ~hold. out_data = main contents; equals FLUSH_VAL when empty after reset or flush.
- in_ready:
  - SKID=1: ~skid_full & ~hold. skid_full is a flop, so no combinational path from out_ready.
  - SKID=0: (~main_full | out_ready) & ~hold.
- Transitions (when flush=0 and hold=0):
  - EMPTY + in_fire -> ONE; main <= in_data.
  - ONE + in_fire & out_fire -> ONE; main <= in_data.
  - ONE + out_fire only -> EMPTY.
  - ONE + in_fire only -> TWO (SKID=1); skid <= in_data.
  - TWO + out_fire -> ONE; main <= skid.
  - TWO accepts nothing, because in_ready=0.
- Latency: 1 cycle from in_fire to out_valid when empty. FIFO order is always preserved.
- Freeze / mem_ready=0: no state change, no beats accepted or emitted, contents and out_data stable. A held beat reappears on out_valid when hold drops.
- Flush: highest priority after reset. Next edge sets state EMPTY and out_data to FLUSH_VAL. Any in_data offered that cycle is discarded. Flush overrides a simultaneous freeze.
- stall_cnt: increments each cycle that main_full & ~out_fire (hold or backpressure). Saturates at 2^CNT_W-1. Cleared only by reset, not by flush.
- Reset mid-operation: all beats lost; outputs go to reset values immediately, asynchronously.

Decomposition:
- Shared pipeline package: state encoding (ST_EMPTY, ST_ONE, ST_TWO), default widths (PC_W=32, INSTR_W=32), and FLUSH_VAL constants for NOP-style bubbles.
- One natural sub-module, sat_counter (CNT_W, enable, async active-low reset), reused by other performance counters.
- Skid storage stays inline.

Test Plan:
- Reset then stream: DATA_W=64; send 0x1, 0x2, 0x3 back-to-back with out_ready=1. Required: out_data 0x1, 0x2, 0x3 on consecutive cycles, one cycle after each input; stall_cnt=0.
- Backpressure, SKID=1: send 0xA, 0xB with out_ready=0. Required: in_ready drops to 0 after 0xB. Raise out_ready: 0xA, then 0xB, in order, nothing lost. stall_cnt counts every cycle main was full and not drained.
- Freeze / mem_ready: hold beat 0x55, assert freeze for 3 cycles, then mem_ready=0 for 2 cycles. Required: out_valid=0, in_ready=0 and out_data=0x55 throughout; 0x55 is emitted on release; stall_cnt += 5.
- Flush with TWO occupied and in_valid=1 (0xC), freeze=1 on the same cycle. Required: next cycle out_valid=0, out_data=FLUSH_VAL, 0xC never emitted, stall_cnt unchanged.
- Saturation and reset: CNT_W=4; stall 20 cycles. Required: stall_cnt=15. Pulse rst low mid-beat: outputs go to reset values without waiting for a clock edge.
- SKID=0 variant: out_ready toggled each cycle with continuous input. Required: in_ready follows out_ready in the same cycle; no beat duplicated or dropped.
